// File: rtl/idma_obi_ctrl_mc_bridge_pkg.sv
// Tile-level address constant and the OBI / iDMA reg32_3d frontend port types used by the
// control bridge.
package idma_obi_ctrl_mc_bridge_pkg;

  localparam logic [31:0] IDMA_CTRL_ADDR_START = 32'h0002_0000;
  localparam int unsigned ObiAidWidth = 4;

  typedef struct packed {
    logic [31:0]            addr;
    logic                   we;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic [ObiAidWidth-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0]            rdata;
    logic                   err;
    logic [ObiAidWidth-1:0] rid;
    logic                   r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } idma_fe_reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } idma_fe_reg_rsp_t;

endpackage

// File: rtl/idma_obi_ctrl_mc_bridge.sv
// OBI slave to N-channel iDMA reg32_3d frontend bridge: decodes channel and register offset,
// forwards with valid/ready and returns a registered OBI response (error and timeout aware).
module idma_obi_ctrl_mc_bridge
  import idma_obi_ctrl_mc_bridge_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter logic [31:0] BASE_ADDR = IDMA_CTRL_ADDR_START,
  parameter logic [31:0] CH_STRIDE = 32'h200,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  obi_req_t                    obi_req_i,
  output obi_rsp_t                    obi_rsp_o,
  output idma_fe_reg_req_t [N_CH-1:0] idma_req_o,
  input  idma_fe_reg_rsp_t [N_CH-1:0] idma_rsp_i,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int unsigned ChW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned StrideLog = $clog2(CH_STRIDE);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StErr} state_e;

  state_e                 state_q, state_d;
  logic [ChW-1:0]         ch_q, ch_d;
  logic [11:0]            off_q, off_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [ObiAidWidth-1:0] aid_q, aid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic [31:0] rel, ch_full, off_full;
  logic        dec_valid, gnt, rvalid;

  // Register map: contiguous words 0x00..0xC0, then even words 0xD0..0x110.
  function automatic logic off_ok(input logic [31:0] off);
    return (off[1:0] == 2'b00) &&
           ((off <= 32'h0C0) || ((off >= 32'h0D0) && (off <= 32'h110) && !off[2]));
  endfunction

  always_comb begin
    rel       = obi_req_i.a.addr - BASE_ADDR;
    ch_full   = rel >> StrideLog;
    off_full  = rel & (CH_STRIDE - 32'd1);
    dec_valid = (obi_req_i.a.addr >= BASE_ADDR) && (ch_full < N_CH) && off_ok(off_full);
  end

  // The error cycle is handled like a response cycle, so it can also accept the next access.
  assign gnt = obi_req_i.req && (state_q != StReq);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    off_d     = off_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (idma_rsp_i[ch_q].ready) begin
          rdata_d = idma_rsp_i[ch_q].rdata;
          err_d   = idma_rsp_i[ch_q].error;
          state_d = StRsp;
        end else if ((TIMEOUT != 16'd0) && (cnt_d == TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = StErr;
        end
      end
      default: begin
        if (gnt) begin
          ch_d    = ch_full[ChW-1:0];
          off_d   = off_full[11:0];
          we_d    = obi_req_i.a.we;
          be_d    = obi_req_i.a.be;
          wdata_d = obi_req_i.a.wdata;
          aid_d   = obi_req_i.a.aid;
          cnt_d   = 16'd0;
          state_d = dec_valid ? StReq : StErr;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      aid_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      off_q     <= off_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aid_q     <= aid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rvalid = (state_q == StRsp) || (state_q == StErr);

  always_comb begin
    obi_rsp_o          = '0;
    obi_rsp_o.gnt      = gnt;
    obi_rsp_o.rvalid   = rvalid;
    obi_rsp_o.r.rdata  = (state_q == StRsp) ? rdata_q : 32'h0;
    obi_rsp_o.r.err    = (state_q == StErr) || ((state_q == StRsp) && err_q);
    obi_rsp_o.r.rid    = rvalid ? aid_q : '0;
  end

  always_comb begin
    idma_req_o = '0;
    if (state_q == StReq) begin
      idma_req_o[ch_q].addr  = {20'h0, off_q};
      idma_req_o[ch_q].write = we_q;
      idma_req_o[ch_q].wdata = wdata_q;
      idma_req_o[ch_q].wstrb = be_q;
      idma_req_o[ch_q].valid = 1'b1;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_idma_obi_ctrl_mc_bridge.sv
// Self-checking bench: table-driven accesses with a response scoreboard, plus back-to-back
// and mid-access reset sequences.
module tb_idma_obi_ctrl_mc_bridge;
  import idma_obi_ctrl_mc_bridge_pkg::*;

  localparam int unsigned NCh    = 2;
  localparam logic [31:0] Base   = IDMA_CTRL_ADDR_START;
  localparam logic [31:0] Stride = 32'h200;
  localparam int          Tmo    = 8;

  logic clk = 1'b0;
  logic rst;
  obi_req_t                   obi_req;
  obi_rsp_t                   obi_rsp;
  idma_fe_reg_req_t [NCh-1:0] idma_req;
  idma_fe_reg_rsp_t [NCh-1:0] idma_rsp;
  logic                       busy, tmo;

  always #5 clk = ~clk;

  idma_obi_ctrl_mc_bridge #(
    .N_CH      (NCh),
    .BASE_ADDR (Base),
    .CH_STRIDE (Stride),
    .TIMEOUT   (16'(Tmo))
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .obi_req_i  (obi_req),
    .obi_rsp_o  (obi_rsp),
    .idma_req_o (idma_req),
    .idma_rsp_i (idma_rsp),
    .busy_o     (busy),
    .timeout_o  (tmo)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  aid;
    int          delay;     // cycle of REQ at which ready is given; 0 = never
    logic [31:0] fe_rdata;
    logic        fe_err;
    logic        exp_ok;
    int          exp_ch;
    logic [11:0] exp_off;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
    int          cycle;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_tmo   = 0;
  bit   mon_en  = 1'b0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (tmo) n_tmo++;
      if (obi_rsp.rvalid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rvalid rid=%h at cycle %0d, expected none",
                   obi_rsp.r.rid, cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 128'(obi_rsp.r.rdata), 128'(e.rdata));
          check("rsp_err", 128'(obi_rsp.r.err), 128'(e.err));
          check("rsp_rid", 128'(obi_rsp.r.rid), 128'(e.rid));
          check("rsp_cycle", 128'(cyc), 128'(e.cycle));
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input logic [3:0] rid,
                          input int cycle);
    exp_t x;
    x.rdata = rdata;
    x.err   = err;
    x.rid   = rid;
    x.cycle = cycle;
    sb.push_back(x);
  endtask

  task automatic run_vec(input vec_t v);
    int               t;
    bit               got;
    idma_fe_reg_req_t er;
    @(posedge clk);
    #1;
    obi_req.req     = 1'b1;
    obi_req.a.addr  = v.addr;
    obi_req.a.we    = v.we;
    obi_req.a.be    = v.be;
    obi_req.a.wdata = v.wdata;
    obi_req.a.aid   = v.aid;
    idma_rsp        = '0;
    if (v.exp_ok) begin
      idma_rsp[v.exp_ch].rdata = v.fe_rdata;
      idma_rsp[v.exp_ch].error = v.fe_err;
    end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (obi_rsp.gnt) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_timeout: got no gnt for aid %h, expected gnt", v.aid);
      obi_req.req = 1'b0;
      return;
    end
    t = cyc;
    if (!v.exp_ok) push_exp(32'h0, 1'b1, v.aid, t + 1);
    else if (v.delay == 0) push_exp(32'h0, 1'b1, v.aid, t + Tmo + 1);
    else push_exp(v.exp_rdata, v.exp_err, v.aid, t + v.delay + 1);
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
    if (!v.exp_ok) begin
      @(negedge clk);
      check("fe_idle_on_decode_err", 128'(idma_req), 128'(0));
      return;
    end
    er       = '0;
    er.addr  = {20'h0, v.exp_off};
    er.write = v.we;
    er.wdata = v.wdata;
    er.wstrb = v.be;
    er.valid = 1'b1;
    for (int i = 1; i <= Tmo; i++) begin
      idma_rsp[v.exp_ch].ready = (v.delay == i);
      @(negedge clk);
      check("fe_req", 128'(idma_req[v.exp_ch]), 128'(er));
      check("fe_other_ch", 128'(idma_req[1 - v.exp_ch]), 128'(0));
      @(posedge clk);
      #1;
      idma_rsp[v.exp_ch].ready = 1'b0;
      if (v.delay == i) break;
    end
    @(negedge clk);
    check("fe_drop", 128'(idma_req), 128'(0));
    check("timeout_pulse", 128'(tmo), 128'(v.delay == 0));
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    obi_req  = '0;
    idma_rsp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_obi_rsp", 128'(obi_rsp), 128'(0));
    check("rst_idma_req", 128'(idma_req), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_timeout", 128'(tmo), 128'(0));
    mon_en = 1'b1;

    vecs[0]  = '{Base + 32'h004, 1'b0, 32'h0, 4'hF, 4'd1, 3, 32'hA5A5_0001, 1'b0,
                 1'b1, 0, 12'h004, 32'hA5A5_0001, 1'b0};
    vecs[1]  = '{Base + 32'h2D0, 1'b1, 32'h1000, 4'hF, 4'd2, 1, 32'h0, 1'b0,
                 1'b1, 1, 12'h0D0, 32'h0, 1'b0};
    vecs[2]  = '{Base + 32'h0C4, 1'b0, 32'h0, 4'hF, 4'd3, 1, 32'h0, 1'b0,
                 1'b0, 0, 12'h0, 32'h0, 1'b1};
    vecs[3]  = '{Base + 32'h400, 1'b0, 32'h0, 4'hF, 4'd4, 1, 32'h0, 1'b0,
                 1'b0, 0, 12'h0, 32'h0, 1'b1};
    vecs[4]  = '{Base - 32'h004, 1'b0, 32'h0, 4'hF, 4'd5, 1, 32'h0, 1'b0,
                 1'b0, 0, 12'h0, 32'h0, 1'b1};
    vecs[5]  = '{Base + 32'h310, 1'b0, 32'h0, 4'h3, 4'd6, 2, 32'hDEAD_BEEF, 1'b1,
                 1'b1, 1, 12'h110, 32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{Base + 32'h000, 1'b0, 32'h0, 4'hF, 4'd7, 1, 32'h0000_1234, 1'b0,
                 1'b1, 0, 12'h000, 32'h0000_1234, 1'b0};
    vecs[7]  = '{Base + 32'h312, 1'b0, 32'h0, 4'hF, 4'd8, 1, 32'h0, 1'b0,
                 1'b0, 0, 12'h0, 32'h0, 1'b1};
    vecs[8]  = '{Base + 32'h308, 1'b0, 32'h0, 4'hF, 4'd9, Tmo, 32'h0000_0055, 1'b0,
                 1'b1, 1, 12'h108, 32'h0000_0055, 1'b0};
    vecs[9]  = '{Base + 32'h040, 1'b0, 32'h0, 4'hF, 4'd10, 0, 32'h0000_0077, 1'b0,
                 1'b1, 0, 12'h040, 32'h0, 1'b1};
    vecs[10] = '{Base + 32'h0C0, 1'b1, 32'h0000_CAFE, 4'h5, 4'd11, 1, 32'h0000_0099, 1'b0,
                 1'b1, 0, 12'h0C0, 32'h0000_0099, 1'b0};
    vecs[11] = '{Base + 32'h2CC, 1'b0, 32'h0, 4'hF, 4'd12, 1, 32'h0, 1'b0,
                 1'b0, 0, 12'h0, 32'h0, 1'b1};

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back reads with a zero-wait frontend on both channels.
    @(posedge clk);
    #1;
    idma_rsp          = '0;
    idma_rsp[0].ready = 1'b1;
    idma_rsp[0].rdata = 32'h0000_AAAA;
    idma_rsp[1].ready = 1'b1;
    idma_rsp[1].rdata = 32'h0000_BBBB;
    obi_req.req       = 1'b1;
    obi_req.a.addr    = Base + 32'h008;
    obi_req.a.we      = 1'b0;
    obi_req.a.be      = 4'hF;
    obi_req.a.wdata   = 32'h0;
    obi_req.a.aid     = 4'd13;
    @(negedge clk);
    check("b2b_gnt_first", 128'(obi_rsp.gnt), 128'(1));
    t = cyc;
    push_exp(32'h0000_AAAA, 1'b0, 4'd13, t + 2);
    @(posedge clk);
    #1;
    obi_req.a.addr = Base + 32'h20C;
    obi_req.a.aid  = 4'd14;
    @(negedge clk);
    check("b2b_no_gnt_in_req", 128'(obi_rsp.gnt), 128'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_gnt_with_rvalid", 128'({obi_rsp.gnt, obi_rsp.rvalid}), 128'(2'b11));
    push_exp(32'h0000_BBBB, 1'b0, 4'd14, t + 4);
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
    @(negedge clk);
    check("b2b_ch1_valid", 128'({idma_req[1].valid, idma_req[1].addr}), 128'({1'b1, 32'h00C}));
    check("b2b_ch0_idle", 128'(idma_req[0]), 128'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    idma_rsp = '0;

    // Reset while waiting on the frontend: no response for the aborted access.
    obi_req.req    = 1'b1;
    obi_req.a.addr = Base + 32'h010;
    obi_req.a.aid  = 4'd15;
    @(negedge clk);
    check("rst_seq_gnt", 128'(obi_rsp.gnt), 128'(1));
    @(posedge clk);
    #1;
    obi_req.req = 1'b0;
    @(negedge clk);
    check("rst_seq_valid_before", 128'(idma_req[0].valid), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_seq_valid_after", 128'(idma_req), 128'(0));
    check("rst_seq_busy_after", 128'(busy), 128'(0));
    repeat (Tmo + 4) @(posedge clk);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    check("timeout_count", 128'(n_tmo), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
